fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Forwarding and hazard controller for the RV32 integer pipeline (IF/ID/EX/MEM/WB). It tracks destination-register state for the EX, MEM and WB stages and drives the 2-bit selects of the two 3-input operand muxes in EX. The select encoding is 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result. It also detects load-use hazards, stalls IF/ID, injects an EX bubble, and counts stall cycles. It sits beside the decoder and feeds the operand-A and operand-B mux select lines.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter
REG_AW, 5, register address width

Ports:
clk  in  1  pipeline clock
reset_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  ID source register 1
id_rs2  in  REG_AW  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_AW  ID destination register
id_we  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
flush  in  1  branch/jump redirect; kill the ID instruction
mem_stall  in  1  data memory not ready; freeze the whole pipeline
fwd_sel_a  out  2  operand-A mux select for the EX instruction
fwd_sel_b  out  2  operand-B mux select for the EX instruction
stall_if_id  out  1  hold the PC and the IF/ID register
bubble_ex  out  1  EX receives a NOP this edge
stall_count  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Clock and reset: single clock `clk`; reset `reset_n` is synchronous and active-low.
- Internal stage state:
  - EX slot: rs1, rs2, use1, use2, rd, we, ld.
  - MEM slot: rd, we, ld.
  - WB slot: rd, we.
- Reset (reset_n=0 at an edge): every we/ld/use bit clears, stall_count=0. Outputs then settle to fwd_sel_a=fwd_sel_b=00 and stall_if_id=bubble_ex=0. Reset overrides a pending stall, flush or mem_stall.
- Select generation is combinational from registered state, so it is valid in the same cycle the instruction occupies EX. Per operand X (a uses rs1/use1, b uses rs2/use2):
  - 01 if useX && mem_we && mem_rd!=0 && mem_rd==ex_rsX;
  - else 10 if useX && wb_we && wb_rd!=0 && wb_rd==ex_rsX;
  - else 00.
  - MEM takes priority over WB (newest value wins).
  - 11 is never driven.
- Load-use hazard, combinational: hz = id_valid && !flush && ex_we && ex_ld && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - stall_if_id = hz && !mem_stall.
  - bubble_ex = (hz || flush) && !mem_stall.
- Stage advance at each edge when mem_stall=0:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (all we/ld/use cleared) if bubble_ex, else the ID fields with we/use gated by id_valid.
- mem_stall=1: all slots hold and the selects stay stable; hz is suppressed and the counter is not incremented.
- stall_count increments by 1 at each edge where stall_if_id=1, and saturates at all-ones.
- A load-use stall lasts exactly 1 cycle. After the bubble the load is in MEM, and the consumer's next ID cycle finds no hazard. When the consumer then reaches EX, the load is in WB, so the select is 10.
- Invariant (bench assertion): a select of 01 is never generated while mem_ld=1.
- Simultaneous flush and hz: the flush wins. The ID instruction is killed, stall_if_id=0 and the counter is not incremented.

Decomposition:
- Select encodings (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and the `BITS2`/`BITS5` width macros belong in the shared riscv.vh header.
- One sub-module, fwd_sel_unit, instantiated twice (once per operand). Inputs: ex_rs, use, mem_rd, mem_we, wb_rd, wb_we. Output: the 2-bit select.

Test Plan:
1. `add x5` then `sub x6,x5,x1` back-to-back -> sub in EX: fwd_sel_a=01, fwd_sel_b=00.
2. `add x5`, nop, then use of x5 as rs2 -> fwd_sel_b=10. With writes to x5 in both MEM and WB -> fwd_sel_b=01.
3. `addi x0,x0,1` followed by a use of x0 -> both selects 00 throughout.
4. `lw x7` then `add x8,x1,x7` -> stall_if_id=1 and bubble_ex=1 for exactly one cycle, then add in EX with fwd_sel_b=10, stall_count=1.
5. Load-use hazard with mem_stall=1 for 3 cycles -> stall_if_id=0, selects constant and stall_count unchanged during the freeze; after release, a 1-cycle stall occurs and stall_count increments by 1.
6. reset_n=0 during a load-use stall with flush=1 -> after the edge all outputs are 0 and the stage state is empty. A forced 2^16+3 stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_ctrl_pkg
//  Description : Shared encodings for the RV32 forwarding/hazard controller.
//                EX operand mux selects:
//                  FWD_RF  (00) register-file value
//                  FWD_MEM (01) EX/MEM result
//                  FWD_WB  (10) MEM/WB result
//                Encoding 11 is never driven.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_ctrl_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage : fwd_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/fwd_sel_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_unit
//  Description : Operand forwarding select for one EX source operand.
//                The MEM stage holds the newest in-flight value, so it takes
//                priority over WB. x0 is hard-wired zero and never forwarded.
//  Ports       : ex_rs   - source register of the EX instruction
//                use_rs  - EX instruction actually reads ex_rs
//                mem_rd  - destination register in MEM
//                mem_we  - MEM instruction writes mem_rd
//                wb_rd   - destination register in WB
//                wb_we   - WB instruction writes wb_rd
//                sel     - 2-bit operand mux select
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel_unit
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (use_rs && mem_we && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (use_rs && wb_we && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_sel_unit
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_ctrl
//  Description : Forwarding and load-use hazard controller for the RV32
//                five-stage pipeline. Tracks destination-register state of
//                the EX, MEM and WB stages, drives the EX operand-A/B mux
//                selects, stalls IF/ID and bubbles EX on a load-use hazard,
//                and counts load-use stall cycles (saturating).
//  Ports       : clk, reset_n (synchronous, active-low)
//                id_*        - decoded fields of the ID instruction
//                flush       - redirect; kills the ID instruction
//                mem_stall   - freezes the whole pipeline
//                fwd_sel_a/b - EX operand mux selects
//                stall_if_id - hold PC and IF/ID
//                bubble_ex   - EX receives a NOP at this edge
//                stall_count - saturating load-use stall cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_count
);

    // EX slot
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_use1;
    logic              r_ex_use2;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_we;
    logic              r_ex_ld;
    // MEM slot
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_we;
    logic              r_mem_ld;
    // WB slot
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_we;

    logic [CNT_W-1:0]  r_stall_count;

    logic              w_hz;
    logic              w_ex_live;
    logic              w_unused_mem_ld;

    // A load in MEM cannot be a forwarding source; the hazard logic already
    // guarantees no consumer reaches EX while its load sits in MEM, so the
    // flag is tracked for stage bookkeeping only.
    assign w_unused_mem_ld = r_mem_ld;

    // Load-use: the load result is only available from WB onwards, so a
    // dependent instruction in ID must wait one cycle. A flush kills the ID
    // instruction, so a hazard on it is moot.
    assign w_hz = id_valid && !flush && r_ex_we && r_ex_ld && (r_ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == r_ex_rd)));

    assign stall_if_id = w_hz && !mem_stall;
    assign bubble_ex   = (w_hz || flush) && !mem_stall;
    assign stall_count = r_stall_count;

    // ID instruction enters EX as a real instruction only if valid and not bubbled
    assign w_ex_live   = id_valid && !bubble_ex;

    fwd_sel_unit #(
        .REG_AW (REG_AW)
    ) u_sel_a (
        .ex_rs  (r_ex_rs1),
        .use_rs (r_ex_use1),
        .mem_rd (r_mem_rd),
        .mem_we (r_mem_we),
        .wb_rd  (r_wb_rd),
        .wb_we  (r_wb_we),
        .sel    (fwd_sel_a)
    );

    fwd_sel_unit #(
        .REG_AW (REG_AW)
    ) u_sel_b (
        .ex_rs  (r_ex_rs2),
        .use_rs (r_ex_use2),
        .mem_rd (r_mem_rd),
        .mem_we (r_mem_we),
        .wb_rd  (r_wb_rd),
        .wb_we  (r_wb_we),
        .sel    (fwd_sel_b)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_use1     <= 1'b0;
            r_ex_use2     <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_we       <= 1'b0;
            r_ex_ld       <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_we      <= 1'b0;
            r_mem_ld      <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_we       <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if (!mem_stall) begin
                r_wb_rd   <= r_mem_rd;
                r_wb_we   <= r_mem_we;
                r_mem_rd  <= r_ex_rd;
                r_mem_we  <= r_ex_we;
                r_mem_ld  <= r_ex_ld;
                // Register fields are don't-care when the flags are clear
                r_ex_rs1  <= id_rs1;
                r_ex_rs2  <= id_rs2;
                r_ex_rd   <= id_rd;
                r_ex_use1 <= w_ex_live && id_use_rs1;
                r_ex_use2 <= w_ex_live && id_use_rs2;
                r_ex_we   <= w_ex_live && id_we;
                r_ex_ld   <= w_ex_live && id_is_load;
            end
            // stall_if_id is already qualified by !mem_stall
            if (stall_if_id && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

endmodule : fwd_hazard_ctrl
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_ctrl
//  Description : Self-checking bench for fwd_hazard_ctrl. One row of the
//                vector table is one pipeline cycle: ID inputs applied at the
//                falling edge, outputs compared before the next rising edge.
//                A second instance with a 4-bit counter exercises counter
//                saturation within a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int NROWS = 32;

    typedef struct {
        logic        rn;
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        fl;
        logic        ms;
        logic [1:0]  ea;
        logic [1:0]  eb;
        logic        es;
        logic        ebub;
        logic [15:0] ec;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        flush;
    logic        mem_stall;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        stall_if_id;
    logic        bubble_ex;
    logic [15:0] stall_count;

    logic [1:0]  s_sel_a;
    logic [1:0]  s_sel_b;
    logic        s_stall;
    logic        s_bubble;
    logic [3:0]  s_count;

    int          n_cmp;
    int          n_bad;
    logic        sh_ex_ld;
    logic        sh_mem_ld;
    vec_t        tbl [NROWS];

    fwd_hazard_ctrl #(.CNT_W(16), .REG_AW(5)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .mem_stall   (mem_stall),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .stall_count (stall_count)
    );

    fwd_hazard_ctrl #(.CNT_W(4), .REG_AW(5)) u_dut_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .mem_stall   (mem_stall),
        .fwd_sel_a   (s_sel_a),
        .fwd_sel_b   (s_sel_b),
        .stall_if_id (s_stall),
        .bubble_ex   (s_bubble),
        .stall_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int rn, v, rs1, rs2, u1, u2, rd, we, ld,
                                fl, ms, ea, eb, es, ebub, ec);
        vec_t m;
        m.rn   = 1'(rn);   m.v    = 1'(v);
        m.rs1  = 5'(rs1);  m.rs2  = 5'(rs2);
        m.u1   = 1'(u1);   m.u2   = 1'(u2);
        m.rd   = 5'(rd);   m.we   = 1'(we);   m.ld = 1'(ld);
        m.fl   = 1'(fl);   m.ms   = 1'(ms);
        m.ea   = 2'(ea);   m.eb   = 2'(eb);
        m.es   = 1'(es);   m.ebub = 1'(ebub); m.ec = 16'(ec);
        return m;
    endfunction

    task automatic drive(input vec_t t);
        reset_n    = t.rn;
        id_valid   = t.v;
        id_rs1     = t.rs1;
        id_rs2     = t.rs2;
        id_use_rs1 = t.u1;
        id_use_rs2 = t.u2;
        id_rd      = t.rd;
        id_we      = t.we;
        id_is_load = t.ld;
        flush      = t.fl;
        mem_stall  = t.ms;
    endtask

    task automatic apply_row(input vec_t t, input int idx);
        @(negedge clk);
        drive(t);
        #1;
        n_cmp++;
        if ({fwd_sel_a, fwd_sel_b, stall_if_id, bubble_ex, stall_count} !==
            {t.ea, t.eb, t.es, t.ebub, t.ec}) begin
            n_bad++;
            $display("FAIL row%0d: got a=%b b=%b stall=%b bub=%b cnt=%0d, want a=%b b=%b stall=%b bub=%b cnt=%0d",
                     idx, fwd_sel_a, fwd_sel_b, stall_if_id, bubble_ex, stall_count,
                     t.ea, t.eb, t.es, t.ebub, t.ec);
        end
        // A load sitting in MEM must never be selected as a forwarding source
        n_cmp++;
        if (sh_mem_ld && (fwd_sel_a == 2'b01 || fwd_sel_b == 2'b01)) begin
            n_bad++;
            $display("FAIL row%0d inv_mem_ld: got a=%b b=%b with load in MEM, want no 01",
                     idx, fwd_sel_a, fwd_sel_b);
        end
        @(posedge clk);
        if (!t.rn) begin
            sh_ex_ld  = 1'b0;
            sh_mem_ld = 1'b0;
        end else if (!t.ms) begin
            sh_mem_ld = sh_ex_ld;
            sh_ex_ld  = t.ebub ? 1'b0 : (t.v && t.ld);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t t_rst, t_lw, t_use;
        n_cmp     = 0;
        n_bad     = 0;
        sh_ex_ld  = 1'b0;
        sh_mem_ld = 1'b0;

        //          rn v rs1 rs2 u1 u2 rd we ld fl ms  ea eb es bub cnt
        tbl[0]  = mk(1,1, 1, 2, 1,1, 5, 1,0, 0,0, 0,0,0,0,0); // add x5,x1,x2
        tbl[1]  = mk(1,1, 5, 1, 1,1, 6, 1,0, 0,0, 0,0,0,0,0); // sub x6,x5,x1
        tbl[2]  = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 1,0,0,0,0); // sub in EX: a from MEM
        tbl[3]  = mk(1,1, 3, 4, 1,1, 5, 1,0, 0,0, 0,0,0,0,0); // add x5,x3,x4
        tbl[4]  = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,0,0,0,0); // nop
        tbl[5]  = mk(1,1, 1, 5, 1,1, 9, 1,0, 0,0, 0,0,0,0,0); // or x9,x1,x5
        tbl[6]  = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,2,0,0,0); // or in EX: b from WB
        tbl[7]  = mk(1,1, 1, 1, 1,1, 5, 1,0, 0,0, 0,0,0,0,0); // add x5
        tbl[8]  = mk(1,1, 2, 2, 1,1, 5, 1,0, 0,0, 0,0,0,0,0); // add x5 again
        tbl[9]  = mk(1,1, 1, 5, 1,1,10, 1,0, 0,0, 0,0,0,0,0); // and x10,x1,x5
        tbl[10] = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,1,0,0,0); // x5 in MEM and WB: MEM wins
        tbl[11] = mk(1,1, 0, 0, 1,0, 0, 1,0, 0,0, 0,0,0,0,0); // addi x0,x0,1
        tbl[12] = mk(1,1, 0, 0, 1,1,11, 1,0, 0,0, 0,0,0,0,0); // add x11,x0,x0
        tbl[13] = mk(1,1, 0, 0, 1,1,12, 1,0, 0,0, 0,0,0,0,0); // add x12,x0,x0 (x0 in MEM)
        tbl[14] = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,0,0,0,0); // x0 in WB: still RF
        tbl[15] = mk(1,1, 1, 0, 1,0, 7, 1,1, 0,0, 0,0,0,0,0); // lw x7,0(x1)
        tbl[16] = mk(1,1, 1, 7, 1,1, 8, 1,0, 0,0, 0,0,1,1,0); // add x8,x1,x7: load-use
        tbl[17] = mk(1,1, 1, 7, 1,1, 8, 1,0, 0,0, 0,0,0,0,1); // held add, no hazard now
        tbl[18] = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,2,0,0,1); // add in EX: b from WB
        tbl[19] = mk(1,1, 8, 0, 1,0, 3, 1,1, 0,0, 0,0,0,0,1); // lw x3,0(x8)
        tbl[20] = mk(1,1, 3, 3, 1,1, 4, 1,0, 0,1, 2,0,0,0,1); // sub x4,x3,x3 frozen
        tbl[21] = mk(1,1, 3, 3, 1,1, 4, 1,0, 0,1, 2,0,0,0,1);
        tbl[22] = mk(1,1, 3, 3, 1,1, 4, 1,0, 0,1, 2,0,0,0,1);
        tbl[23] = mk(1,1, 3, 3, 1,1, 4, 1,0, 0,0, 2,0,1,1,1); // released: 1-cycle stall
        tbl[24] = mk(1,1, 3, 3, 1,1, 4, 1,0, 0,0, 0,0,0,0,2);
        tbl[25] = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 2,2,0,0,2); // sub in EX: both from WB
        tbl[26] = mk(1,1, 0, 0, 1,0,13, 1,1, 0,0, 0,0,0,0,2); // lw x13,0(x0)
        tbl[27] = mk(1,1,13, 0, 1,1,14, 1,0, 1,0, 0,0,0,1,2); // hazard + flush: flush wins
        tbl[28] = mk(1,1,13, 0, 1,0,15, 1,1, 0,0, 0,0,0,0,2); // lw x15,0(x13)
        tbl[29] = mk(0,1,15,15, 1,1,16, 1,0, 1,0, 2,0,0,1,2); // reset with flush pending
        tbl[30] = mk(1,1,15, 0, 1,0,18, 1,0, 0,0, 0,0,0,0,0); // after reset: all empty
        tbl[31] = mk(1,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,0,0,0,0); // x15 producer was cleared

        t_rst = mk(0,0, 0, 0, 0,0, 0, 0,0, 0,0, 0,0,0,0,0);
        t_lw  = mk(1,1, 1, 0, 1,0, 7, 1,1, 0,0, 0,0,0,0,0);
        t_use = mk(1,1, 1, 7, 0,1, 8, 1,0, 0,0, 0,0,0,0,0);

        // Initial reset, held across a mem_stall/flush to show reset dominates
        @(negedge clk);
        drive(t_rst);
        flush     = 1'b1;
        mem_stall = 1'b1;
        @(negedge clk);
        drive(t_rst);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({fwd_sel_a, fwd_sel_b, stall_if_id, bubble_ex, stall_count, s_count} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_state: got a=%b b=%b stall=%b bub=%b cnt=%0d scnt=%0d, want all 0",
                     fwd_sel_a, fwd_sel_b, stall_if_id, bubble_ex, stall_count, s_count);
        end
        @(posedge clk);

        for (int i = 0; i < NROWS; i++) begin
            apply_row(tbl[i], i);
        end

        // Back-to-back load/consumer pairs: one stall per pair
        @(negedge clk);
        drive(t_rst);
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            drive(t_lw);
            @(negedge clk);
            drive(t_use);
            #1;
            if (k == 1) begin
                n_cmp++;
                if ({stall_if_id, bubble_ex} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL sat_stall: got stall=%b bub=%b, want 1 1", stall_if_id, bubble_ex);
                end
            end
            @(posedge clk);
            #1;
            if (k == 15) check_cnt("sat_cnt4_at15", {12'd0, s_count}, 16'd15);
            if (k == 16) check_cnt("sat_cnt4_at16", {12'd0, s_count}, 16'd15);
            if (k == 16) check_cnt("cnt16_at16", stall_count, 16'd16);
            if (k == 19) check_cnt("sat_cnt4_at19", {12'd0, s_count}, 16'd15);
            if (k == 19) check_cnt("cnt16_at19", stall_count, 16'd19);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fwd_hazard_ctrl
`default_nettype wire
